// File: rtl/warp_fetch_scheduler_pkg.sv
// Shared types for the warp fetch scheduler: selection mode, FSM states and
// the error-pulse bit masks driven on err.
package warp_fetch_scheduler_pkg;

    typedef enum logic [0:0] {
        FETCH_MODE_RR    = 1'b0,
        FETCH_MODE_FIXED = 1'b1
    } fetch_mode_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } fetch_state_e;

    localparam logic [31:0] ERR_FETCH_EMPTY_MASK = 32'h0000_0001;
    localparam logic [31:0] ERR_FETCH_INIT_BUSY  = 32'h0000_0002;

endpackage

// File: rtl/warp_fetch_scheduler_rr_arbiter.sv
// Combinational rotating-priority arbiter: rotate the request vector so the
// preferred slot sits at bit 0, isolate the lowest set bit, rotate back.
module rr_arbiter #(
    parameter int N = 32,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] off_i,
    input  logic          fixed_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [31:0]  off;
    logic [N-1:0] rot;
    logic [N-1:0] rot_gnt;

    always_comb begin
        off     = fixed_i ? 32'd0 : (32'(off_i) % 32'(N));
        // A shift by N yields zero, so off == 0 degenerates to the plain vector.
        rot     = (req_i >> off) | (req_i << (32'(N) - off));
        rot_gnt = rot & (~rot + ONE);
        gnt_o   = (rot_gnt << off) | (rot_gnt >> (32'(N) - off));
        any_o   = |req_i;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// Warp fetch scheduler: accepts a batch mask of warp slots and issues one
// (warp_id, pc) fetch beat per slot with ready/valid backpressure.
module warp_fetch_scheduler
    import warp_fetch_scheduler_pkg::*;
#(
    parameter int          NUM_WARPS = 32,
    parameter int          PC_W      = 32,
    parameter int          WID_W     = 5,
    parameter fetch_mode_e MODE      = FETCH_MODE_RR,
    localparam int         SW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 initialize,
    input  logic [PC_W-1:0]      init_pc      [NUM_WARPS],
    input  logic [WID_W-1:0]     init_warp_id [NUM_WARPS],
    input  logic [PC_W-1:0]      next_pc      [NUM_WARPS],
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic [NUM_WARPS-1:0] s_warp_mask,
    input  logic [NUM_WARPS-1:0] slot_stall,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [SW-1:0]        m_slot,
    output logic [WID_W-1:0]     m_warp_id,
    output logic [PC_W-1:0]      m_pc,
    output logic [31:0]          err
);

    fetch_state_e          state_q, state_d;
    logic [NUM_WARPS-1:0]  pending_q, pending_d;
    logic [SW-1:0]         last_idx_q, last_idx_d;
    logic                  run_q;
    logic                  vld_q, vld_d;
    logic                  last_q, last_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [WID_W-1:0]      wid_q, wid_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [31:0]           err_q, err_d;

    logic [PC_W-1:0]       pc_tbl_q  [NUM_WARPS];
    logic [WID_W-1:0]      wid_tbl_q [NUM_WARPS];

    logic [NUM_WARPS-1:0]  eligible;
    logic [NUM_WARPS-1:0]  arb_gnt;
    logic [SW-1:0]         arb_idx;
    logic [SW-1:0]         arb_off;
    logic                  arb_any;
    logic                  out_free;
    logic                  tbl_load;
    logic                  grant_en;

    assign eligible = pending_q & ~slot_stall;
    assign arb_off  = (last_idx_q == SW'(NUM_WARPS - 1)) ? '0 : last_idx_q + SW'(1);
    assign out_free = ~vld_q | m_tready;

    rr_arbiter #(.N(NUM_WARPS)) u_arb (
        .req_i   (eligible),
        .off_i   (arb_off),
        .fixed_i (MODE == FETCH_MODE_FIXED),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        last_idx_d = last_idx_q;
        vld_d      = vld_q;
        last_d     = last_q;
        slot_d     = slot_q;
        wid_d      = wid_q;
        pc_d       = pc_q;
        err_d      = '0;
        tbl_load   = 1'b0;
        grant_en   = 1'b0;
        s_tready   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // run_q keeps s_tready low until the first edge after reset.
                s_tready = run_q & enable & ~initialize;
                tbl_load = enable & initialize;
                if (s_tvalid && s_tready) begin
                    if (s_warp_mask == '0) begin
                        err_d = ERR_FETCH_EMPTY_MASK;
                    end else begin
                        pending_d = s_warp_mask;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (initialize) err_d = ERR_FETCH_INIT_BUSY;
                if (vld_q && m_tready) begin
                    vld_d = 1'b0;
                    if (last_q) state_d = ST_IDLE;
                end
                if (enable && out_free && arb_any) begin
                    grant_en   = 1'b1;
                    vld_d      = 1'b1;
                    slot_d     = arb_idx;
                    wid_d      = wid_tbl_q[arb_idx];
                    pc_d       = pc_tbl_q[arb_idx];
                    pending_d  = pending_q & ~arb_gnt;
                    last_d     = ((pending_q & ~arb_gnt) == '0);
                    last_idx_d = arb_idx;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            last_idx_q <= SW'(NUM_WARPS - 1);
            run_q      <= 1'b0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            slot_q     <= '0;
            wid_q      <= '0;
            pc_q       <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_idx_q <= last_idx_d;
            run_q      <= 1'b1;
            vld_q      <= vld_d;
            last_q     <= last_d;
            slot_q     <= slot_d;
            wid_q      <= wid_d;
            pc_q       <= pc_d;
            err_q      <= err_d;
        end
    end

    // Table load and per-grant PC advance are mutually exclusive by state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                pc_tbl_q[i]  <= '0;
                wid_tbl_q[i] <= '0;
            end
        end else if (tbl_load) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                pc_tbl_q[i]  <= init_pc[i];
                wid_tbl_q[i] <= init_warp_id[i];
            end
        end else if (grant_en) begin
            pc_tbl_q[arb_idx] <= next_pc[arb_idx];
        end
    end

    assign m_tvalid  = vld_q;
    assign m_tlast   = last_q;
    assign m_slot    = slot_q;
    assign m_warp_id = wid_q;
    assign m_pc      = pc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench: a 32-slot round-robin instance (a) and an 8-slot
// fixed-priority instance (b) sharing clock, reset, enable and initialize.
module tb_warp_fetch_scheduler;
    import warp_fetch_scheduler_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        initialize;

    logic [31:0] init_pc_a  [32];
    logic [4:0]  init_wid_a [32];
    logic [31:0] next_pc_a  [32];
    logic        s_tvalid_a, s_tready_a, m_tvalid_a, m_tready_a, m_tlast_a;
    logic [31:0] s_mask_a, stall_a;
    logic [4:0]  m_slot_a, m_wid_a;
    logic [31:0] m_pc_a, err_a;

    logic [31:0] init_pc_b  [8];
    logic [4:0]  init_wid_b [8];
    logic [31:0] next_pc_b  [8];
    logic        s_tvalid_b, s_tready_b, m_tvalid_b, m_tready_b, m_tlast_b;
    logic [7:0]  s_mask_b, stall_b;
    logic [2:0]  m_slot_b;
    logic [4:0]  m_wid_b;
    logic [31:0] m_pc_b, err_b;

    int n_checks = 0;
    int n_errors = 0;

    warp_fetch_scheduler #(.NUM_WARPS(32), .PC_W(32), .WID_W(5), .MODE(FETCH_MODE_RR)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .initialize(initialize),
        .init_pc(init_pc_a), .init_warp_id(init_wid_a), .next_pc(next_pc_a),
        .s_tvalid(s_tvalid_a), .s_tready(s_tready_a), .s_warp_mask(s_mask_a),
        .slot_stall(stall_a), .m_tvalid(m_tvalid_a), .m_tready(m_tready_a),
        .m_tlast(m_tlast_a), .m_slot(m_slot_a), .m_warp_id(m_wid_a), .m_pc(m_pc_a),
        .err(err_a)
    );

    warp_fetch_scheduler #(.NUM_WARPS(8), .PC_W(32), .WID_W(5), .MODE(FETCH_MODE_FIXED)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .initialize(initialize),
        .init_pc(init_pc_b), .init_warp_id(init_wid_b), .next_pc(next_pc_b),
        .s_tvalid(s_tvalid_b), .s_tready(s_tready_b), .s_warp_mask(s_mask_b),
        .slot_stall(stall_b), .m_tvalid(m_tvalid_b), .m_tready(m_tready_b),
        .m_tlast(m_tlast_b), .m_slot(m_slot_b), .m_warp_id(m_wid_b), .m_pc(m_pc_b),
        .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input string tag, input logic [4:0] slot, input logic [4:0] wid,
                          input logic [31:0] pc, input logic last);
        check({tag, "_vld"}, m_tvalid_a, 1'b1);
        check({tag, "_slot"}, m_slot_a, slot);
        check({tag, "_wid"}, m_wid_a, wid);
        check({tag, "_pc"}, m_pc_a, pc);
        check({tag, "_last"}, m_tlast_a, last);
    endtask

    task automatic beat_b(input string tag, input logic [2:0] slot, input logic [4:0] wid,
                          input logic [31:0] pc, input logic last);
        check({tag, "_vld"}, m_tvalid_b, 1'b1);
        check({tag, "_slot"}, m_slot_b, slot);
        check({tag, "_wid"}, m_wid_b, wid);
        check({tag, "_pc"}, m_pc_b, pc);
        check({tag, "_last"}, m_tlast_b, last);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; initialize = 1'b0;
        s_tvalid_a = 1'b0; s_mask_a = '0; stall_a = '0; m_tready_a = 1'b0;
        s_tvalid_b = 1'b0; s_mask_b = '0; stall_b = '0; m_tready_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            init_pc_a[i]  = 32'h1000 + 32'(4 * i);
            init_wid_a[i] = 5'(31 - i);
            next_pc_a[i]  = init_pc_a[i] + 32'h4;
        end
        init_pc_a[3] = 32'h100;
        next_pc_a[3] = 32'h104;
        for (int i = 0; i < 8; i++) begin
            init_pc_b[i]  = 32'h2000 + 32'(4 * i);
            init_wid_b[i] = 5'(i + 8);
            next_pc_b[i]  = init_pc_b[i] + 32'h100;
        end

        // Reset values
        tick(); tick();
        check("rst_s_tready", s_tready_a, 1'b0);
        check("rst_m_tvalid", m_tvalid_a, 1'b0);
        check("rst_m_tlast", m_tlast_a, 1'b0);
        check("rst_m_slot", m_slot_a, 5'd0);
        check("rst_m_wid", m_wid_a, 5'd0);
        check("rst_m_pc", m_pc_a, 32'd0);
        check("rst_err", err_a, 32'd0);
        check("rst_b_s_tready", s_tready_b, 1'b0);
        rst_n = 1'b1;
        #1 check("post_rst_tready_low", s_tready_a, 1'b0);
        tick();
        check("post_rst_tready_high", s_tready_a, 1'b1);
        enable = 1'b0;
        #1 check("disabled_tready", s_tready_a, 1'b0);
        enable = 1'b1;

        // Table load in IDLE
        initialize = 1'b1;
        #1 check("init_tready", s_tready_a, 1'b0);
        tick();
        initialize = 1'b0;

        // RR batch 0x8000_0011 from last_idx=31
        s_mask_a = 32'h8000_0011; s_tvalid_a = 1'b1; m_tready_a = 1'b1;
        tick();
        s_tvalid_a = 1'b0;
        check("rr_first_latency", m_tvalid_a, 1'b0);
        check("rr_issue_tready", s_tready_a, 1'b0);
        tick(); beat_a("rr0", 5'd0, 5'd31, 32'h1000, 1'b0);
        tick(); beat_a("rr4", 5'd4, 5'd27, 32'h1010, 1'b0);
        tick(); beat_a("rr31", 5'd31, 5'd0, 32'h107C, 1'b1);
        tick();
        check("rr_done_vld", m_tvalid_a, 1'b0);
        check("rr_done_tready", s_tready_a, 1'b1);

        // Backpressure plus initialize while busy
        s_mask_a = 32'h0000_000E; s_tvalid_a = 1'b1;
        tick();
        s_tvalid_a = 1'b0; m_tready_a = 1'b0;
        tick(); beat_a("bp1", 5'd1, 5'd30, 32'h1004, 1'b0);
        initialize = 1'b1; init_pc_a[2] = 32'hDEAD_0000;
        tick();
        initialize = 1'b0; init_pc_a[2] = 32'h1008;
        check("init_busy_err", err_a, ERR_FETCH_INIT_BUSY);
        beat_a("bp1_hold1", 5'd1, 5'd30, 32'h1004, 1'b0);
        tick();
        check("init_busy_err_clr", err_a, 32'd0);
        beat_a("bp1_hold2", 5'd1, 5'd30, 32'h1004, 1'b0);
        tick(); beat_a("bp1_hold3", 5'd1, 5'd30, 32'h1004, 1'b0);
        m_tready_a = 1'b1;
        tick(); beat_a("bp2", 5'd2, 5'd29, 32'h1008, 1'b0);
        tick(); beat_a("bp3", 5'd3, 5'd28, 32'h100, 1'b1);
        tick(); check("bp_done_vld", m_tvalid_a, 1'b0);

        // Slot 3 again: advanced PC, RR wraps from last_idx=3 back to 3
        s_mask_a = 32'h0000_0008; s_tvalid_a = 1'b1;
        tick();
        s_tvalid_a = 1'b0;
        tick(); beat_a("pc_adv", 5'd3, 5'd28, 32'h104, 1'b1);
        tick(); check("pc_adv_done", m_tvalid_a, 1'b0);

        // Empty mask
        s_mask_a = '0; s_tvalid_a = 1'b1;
        tick();
        s_tvalid_a = 1'b0;
        check("empty_err", err_a, ERR_FETCH_EMPTY_MASK);
        check("empty_vld", m_tvalid_a, 1'b0);
        check("empty_idle_tready", s_tready_a, 1'b1);
        tick();
        check("empty_err_clr", err_a, 32'd0);
        check("empty_vld2", m_tvalid_a, 1'b0);

        // FIXED with slot 4 stalled during three grant decisions
        s_mask_b = 8'hF0; stall_b = 8'h10; s_tvalid_b = 1'b1; m_tready_b = 1'b1;
        tick();
        s_tvalid_b = 1'b0;
        tick(); beat_b("fx5", 3'd5, 5'd13, 32'h2014, 1'b0);
        tick(); beat_b("fx6", 3'd6, 5'd14, 32'h2018, 1'b0);
        tick(); beat_b("fx7", 3'd7, 5'd15, 32'h201C, 1'b0);
        stall_b = 8'h00;
        tick(); beat_b("fx4", 3'd4, 5'd12, 32'h2010, 1'b1);
        tick();
        check("fx_done_vld", m_tvalid_b, 1'b0);
        check("fx_done_tready", s_tready_b, 1'b1);

        // Mid-batch reset: a holds slot 8, b is fully stalled in ISSUE
        s_mask_a = 32'h0000_0300; s_tvalid_a = 1'b1; m_tready_a = 1'b0;
        s_mask_b = 8'h03; stall_b = 8'h03; s_tvalid_b = 1'b1;
        tick();
        s_tvalid_a = 1'b0; s_tvalid_b = 1'b0;
        tick();
        beat_a("pre_rst8", 5'd8, 5'd23, 32'h1020, 1'b0);
        check("stalled_b_vld", m_tvalid_b, 1'b0);
        check("stalled_b_tready", s_tready_b, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_vld", m_tvalid_a, 1'b0);
        check("async_rst_slot", m_slot_a, 5'd0);
        check("async_rst_pc", m_pc_a, 32'd0);
        check("async_rst_wid", m_wid_a, 5'd0);
        check("async_rst_b_vld", m_tvalid_b, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rerun_tready", s_tready_a, 1'b1);
        s_mask_a = 32'h0000_0300; s_tvalid_a = 1'b1; m_tready_a = 1'b1;
        tick();
        s_tvalid_a = 1'b0;
        tick(); beat_a("rerun8", 5'd8, 5'd0, 32'h0, 1'b0);
        tick(); beat_a("rerun9", 5'd9, 5'd0, 32'h0, 1'b1);
        tick(); check("rerun_done", m_tvalid_a, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
